if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage of the dual-issue pipeline; the producer side of the IF→ID interface.
- Generates 8-byte-aligned fetch addresses and drives the 64-bit SRAM-like instruction port (req/addr_ok/data_ok).
- Registers each fetched pair as {if_pc, if_inst} for the decode stage and handles stall back-pressure.
- Handles branch (br_bus) and predictor (bp_bus) redirects, discarding in-flight wrong-path data.

Parameters:
- RESET_PC, 32'hbfc0_0000: first fetch address after reset.
- BR_WD, 33: width of the redirect buses, packed as {e, addr[31:0]}.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous assert, active-low.
- stall  in  1  ID cannot accept; output register holds.
- br_bus  in  BR_WD  {br_e, br_addr}: execute-stage redirect.
- bp_bus  in  BR_WD  {bp_e, bp_addr}: predictor redirect.
- inst_sram_req  out  1  fetch request valid.
- inst_sram_addr  out  32  fetch address, bits [2:0] always 0.
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  read data valid this cycle.
- inst_sram_rdata  in  64  {inst@pc+4, inst@pc}.
- if_valid  out  1  if_pc/if_inst hold a valid pair.
- if_pc  out  32  aligned pair address, bits [2:0]=0.
- if_inst  out  64  fetched pair.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, fetch_pc=RESET_PC, drop=0, skid empty.
  - if_valid=0, if_pc=0, if_inst=0, inst_sram_req=0.
- Address: inst_sram_addr={fetch_pc[31:3],3'b000}. At most one request outstanding.
- States:
  - IDLE: req=0; go to REQ next cycle (first cycle after reset release).
  - REQ: req=1.
    - On addr_ok: req_pc←aligned fetch_pc; fetch_pc←aligned fetch_pc+8; go to WAIT.
    - Until addr_ok, the address may change on a redirect; a request is committed only at addr_ok.
  - WAIT: req=0.
    - On data_ok with drop=1: discard data, drop←0, go to REQ.
    - On data_ok with drop=0 and stall=0: output←{1, req_pc, rdata}; go to REQ.
    - On data_ok with drop=0 and stall=1: skid←{req_pc, rdata}; go to HOLD.
  - HOLD: req=0. When stall=0: output←skid; go to REQ.
- Output register update:
  - Updates only when stall=0.
  - If stall=0 and no new data this cycle, if_valid←0 (bubble).
  - Data returning in WAIT is written the same edge as data_ok, so latency is data_ok→if_valid = 1 cycle.
  - Minimum back-to-back throughput: one pair per 2 cycles (REQ+WAIT) with zero-wait SRAM.
- Redirect:
  - Effective redirect = br_e, or (bp_e & ~stall). br_e wins on simultaneous assertion.
  - On redirect:
    - fetch_pc←target (full address; ID selects the slot via its own PC).
    - if_valid←0; skid cleared.
    - WAIT: set drop=1.
    - REQ with addr_ok the same cycle: go to WAIT with drop=1.
    - HOLD: go to REQ.
  - A redirect coinciding with data_ok in WAIT (drop=0): data is discarded, go to REQ.
  - A redirect coinciding with data_ok when drop=1 already: the discard clears the old drop, drop stays 0, go to REQ.
- fetch_pc wraps modulo 2^32 (32'hffff_fff8+8 → 0).
- stall never blocks IDLE→REQ or REQ issue; it only holds the output and forces WAIT→HOLD.

Test Plan:
- Reset release, SRAM with addr_ok=1 and data_ok one cycle later, no stall → addresses bfc00000, bfc00008, bfc00010; if_pc follows that sequence with if_valid pulsing every 2nd cycle; if_inst equals the returned data.
- stall=1 held 3 cycles when data_ok arrives for bfc00008 → state HOLD, req=0, outputs frozen; stall drops → if_pc=bfc00008 and correct data next edge, then request bfc00010.
- br_e=1, br_addr=8000_1234 while in WAIT → returning data discarded (if_valid stays 0); next request addr=8000_1230, then if_pc=8000_1230.
- br_e (target 8000_0000) and bp_e (target 9000_0000) in the same cycle → next addr 8000_0000; with stall=1, bp_e alone is ignored.
- resetn pulsed low mid-WAIT → outputs immediately 0; after release, the first req addr is bfc00000 and the stale data_ok is not forwarded.
- fetch_pc=ffff_fff8 accepted → next request address 0000_0000.

Source files
------------

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction-fetch stage. Issues 8-byte-aligned requests on
//               a 64-bit SRAM-like port (req/addr_ok/data_ok). It presents
//               each fetched pair to decode as {if_pc, if_inst}. It holds
//               the output under stall, using a one-entry skid buffer, and
//               applies branch/predictor redirects. Any wrong-path data
//               still in flight is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int          BR_WD    = 33
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stall,
  input  logic [BR_WD-1:0] br_bus,
  input  logic [BR_WD-1:0] bp_bus,
  output logic             inst_sram_req,
  output logic [31:0]      inst_sram_addr,
  input  logic             inst_sram_addr_ok,
  input  logic             inst_sram_data_ok,
  input  logic [63:0]      inst_sram_rdata,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [63:0]      if_inst
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] req_pc, req_pc_n;
  logic        drop, drop_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic [63:0] skid_inst, skid_inst_n;
  logic        if_valid_n;
  logic [31:0] if_pc_n;
  logic [63:0] if_inst_n;

  logic        br_e, bp_e;
  logic [31:0] br_addr, bp_addr;
  logic        redir;
  logic [31:0] redir_addr;
  logic [31:0] aligned_pc;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign bp_e    = bp_bus[32];
  assign bp_addr = bp_bus[31:0];

  // The predictor only redirects when decode can take the change; the
  // execute-stage branch always redirects and takes priority.
  assign redir      = br_e | (bp_e & ~stall);
  assign redir_addr = br_e ? br_addr : bp_addr;
  assign aligned_pc = {fetch_pc[31:3], 3'b000};

  assign inst_sram_req  = (state == REQ);
  assign inst_sram_addr = aligned_pc;

  // Registers for the FSM state, fetch/request PCs, the skid buffer and the ID output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      req_pc    <= 32'd0;
      drop      <= 1'b0;
      skid_pc   <= 32'd0;
      skid_inst <= 64'd0;
      if_valid  <= 1'b0;
      if_pc     <= 32'd0;
      if_inst   <= 64'd0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      req_pc    <= req_pc_n;
      drop      <= drop_n;
      skid_pc   <= skid_pc_n;
      skid_inst <= skid_inst_n;
      if_valid  <= if_valid_n;
      if_pc     <= if_pc_n;
      if_inst   <= if_inst_n;
    end
  end

  // Next-state, fetch-address, drop-flag and output-register logic.
  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    req_pc_n    = req_pc;
    drop_n      = drop;
    skid_pc_n   = skid_pc;
    skid_inst_n = skid_inst;
    if_valid_n  = if_valid;
    if_pc_n     = if_pc;
    if_inst_n   = if_inst;

    // Output register: a stall freezes it, otherwise an empty cycle becomes
    // a bubble. The state cases below load it when a pair is ready.
    if (!stall) begin
      if_valid_n = 1'b0;
    end

    case (state)
      IDLE: begin
        state_n = REQ;
      end
      REQ: begin
        if (inst_sram_addr_ok) begin
          req_pc_n   = aligned_pc;
          fetch_pc_n = aligned_pc + 32'd8;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (inst_sram_data_ok) begin
          if (drop) begin
            drop_n  = 1'b0;
            state_n = REQ;
          end else if (redir) begin
            // The returning pair is on the wrong path. No drop is needed
            // because nothing else is outstanding.
            state_n = REQ;
          end else if (!stall) begin
            if_valid_n = 1'b1;
            if_pc_n    = req_pc;
            if_inst_n  = inst_sram_rdata;
            state_n    = REQ;
          end else begin
            skid_pc_n   = req_pc;
            skid_inst_n = inst_sram_rdata;
            state_n     = HOLD;
          end
        end else if (redir) begin
          drop_n = 1'b1;
        end
      end
      HOLD: begin
        if (redir) begin
          state_n = REQ;
        end else if (!stall) begin
          if_valid_n = 1'b1;
          if_pc_n    = skid_pc;
          if_inst_n  = skid_inst;
          state_n    = REQ;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // A redirect replaces the fetch address and flushes the output. A
    // request accepted on the same edge is already in flight, so it must
    // be dropped when its data returns.
    if (redir) begin
      fetch_pc_n  = redir_addr;
      if_valid_n  = 1'b0;
      skid_pc_n   = 32'd0;
      skid_inst_n = 64'd0;
      if (state == REQ && inst_sram_addr_ok) begin
        drop_n = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
